// File: rtl/ir_cmd_pkg.sv
// Shared types and NEC constants for the IR command decoder.
package ir_cmd_pkg;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2
  } state_t;

  localparam logic [7:0] NEC_ADDR      = 8'h20;
  localparam logic [7:0] NEC_CMD_UP    = 8'h6A;
  localparam logic [7:0] NEC_CMD_DOWN  = 8'hEA;
  localparam logic [7:0] NEC_CMD_LEFT  = 8'h1A;
  localparam logic [7:0] NEC_CMD_RIGHT = 8'h9A;
  localparam logic [7:0] NEC_CMD_ENTER = 8'h5A;

  // Up/down differ only in bit 0, as do left/right.
  function automatic logic is_opposite(input dir_t a, input dir_t b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/dir_fifo.sv
// Two-entry direction queue; a pop and a push in the same cycle both take effect.
module dir_fifo
  import ir_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       pop,
  input  dir_t       din,
  output dir_t       head,
  output dir_t       tail,
  output logic [1:0] level,
  output logic       full,
  output logic       empty
);

  dir_t       mem [2];
  logic [1:0] lvl;
  logic       do_pop;
  logic       do_push;

  assign full    = (lvl == 2'd2);
  assign empty   = (lvl == 2'd0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      lvl <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10:   lvl <= lvl + 2'd1;
        2'b01:   lvl <= lvl - 2'd1;
        default: lvl <= lvl;
      endcase
    end
  end

  // Storage carries no reset; the level alone says which entries are live.
  always_ff @(posedge clk) begin
    case ({do_push, do_pop})
      2'b10: begin
        if (lvl == 2'd0) mem[0] <= din;
        else             mem[1] <= din;
      end
      2'b01: mem[0] <= mem[1];
      2'b11: begin
        if (lvl == 2'd2) begin
          mem[0] <= mem[1];
          mem[1] <= din;
        end else begin
          mem[0] <= din;
        end
      end
      default: ;
    endcase
  end

  assign head  = mem[0];
  assign tail  = (lvl == 2'd2) ? mem[1] : mem[0];
  assign level = lvl;

endmodule

// File: rtl/ir_cmd_decoder.sv
// Settles, validates and queues NEC IR frames into game directions and ENTER pulses.
// Define IR_CMD_REVERSE_BLOCK_EN to discard directions opposite to the reference direction.
module ir_cmd_decoder
  import ir_cmd_pkg::*;
#(
  parameter int         STABLE_CYCLES = 64,
  parameter logic [7:0] ADDR          = NEC_ADDR,
  parameter logic [7:0] CMD_UP        = NEC_CMD_UP,
  parameter logic [7:0] CMD_DOWN      = NEC_CMD_DOWN,
  parameter logic [7:0] CMD_LEFT      = NEC_CMD_LEFT,
  parameter logic [7:0] CMD_RIGHT     = NEC_CMD_RIGHT,
  parameter logic [7:0] CMD_ENTER     = NEC_CMD_ENTER
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] word,
  input  logic        game_tick,
  output logic [1:0]  dir,
  output logic        dir_changed,
  output logic        enter,
  output logic        cmd_err,
  output logic [1:0]  fifo_level
);

  localparam int                CNT_W    = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t            state, state_nxt;
  logic [31:0]       cand, cand_nxt;
  logic [31:0]       last_word, last_word_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              push_req, enter_nxt, err_nxt, frame_ok;
  dir_t              push_dir;
  logic [7:0]        cmd;

  dir_t              dir_q, ref_dir, fifo_head, fifo_tail;
  logic              fifo_full, fifo_empty, pop, push_ok;
  logic              dir_changed_p1, enter_p1, cmd_err_p1;

  assign cmd      = cand[15:8];
  assign frame_ok = (cand[31:24] == ~cand[23:16]) && (cand[15:8] == ~cand[7:0]);

  always_comb begin
    state_nxt     = state;
    cand_nxt      = cand;
    cnt_nxt       = cnt;
    last_word_nxt = last_word;
    push_req      = 1'b0;
    push_dir      = DIR_UP;
    enter_nxt     = 1'b0;
    err_nxt       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (word != last_word) begin
          cand_nxt  = word;
          cnt_nxt   = '0;
          state_nxt = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (word != cand) begin
          cand_nxt = word;
          cnt_nxt  = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = ST_CHECK;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ST_CHECK: begin
        state_nxt     = ST_IDLE;
        last_word_nxt = cand;
        if (!frame_ok) begin
          err_nxt = 1'b1;
        end else if (cand[31:24] == ADDR) begin
          if (cmd == CMD_ENTER) begin
            enter_nxt = 1'b1;
          end else if (cmd == CMD_UP) begin
            push_req = 1'b1;
            push_dir = DIR_UP;
          end else if (cmd == CMD_DOWN) begin
            push_req = 1'b1;
            push_dir = DIR_DOWN;
          end else if (cmd == CMD_LEFT) begin
            push_req = 1'b1;
            push_dir = DIR_LEFT;
          end else if (cmd == CMD_RIGHT) begin
            push_req = 1'b1;
            push_dir = DIR_RIGHT;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Push filtering compares against where the snake will be heading once the queue drains.
  assign pop     = game_tick && !fifo_empty;
  assign ref_dir = fifo_empty ? dir_q : fifo_tail;
`ifdef IR_CMD_REVERSE_BLOCK_EN
  assign push_ok = push_req && (push_dir != ref_dir) && !is_opposite(push_dir, ref_dir)
                   && (!fifo_full || pop);
`else
  assign push_ok = push_req && (push_dir != ref_dir) && (!fifo_full || pop);
`endif

  dir_fifo u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_ok),
    .pop   (pop),
    .din   (push_dir),
    .head  (fifo_head),
    .tail  (fifo_tail),
    .level (fifo_level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Stage p1: registered state and output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      cand           <= '0;
      cnt            <= '0;
      last_word      <= '0;
      dir_q          <= DIR_RIGHT;
      dir_changed_p1 <= 1'b0;
      enter_p1       <= 1'b0;
      cmd_err_p1     <= 1'b0;
    end else begin
      state          <= state_nxt;
      cand           <= cand_nxt;
      cnt            <= cnt_nxt;
      last_word      <= last_word_nxt;
      if (pop) dir_q <= fifo_head;
      dir_changed_p1 <= pop;
      enter_p1       <= enter_nxt;
      cmd_err_p1     <= err_nxt;
    end
  end

  assign dir         = dir_q;
  assign dir_changed = dir_changed_p1;
  assign enter       = enter_p1;
  assign cmd_err     = cmd_err_p1;

endmodule

// File: tb/tb_ir_cmd_decoder.sv
// Directed bench for ir_cmd_decoder: frame latency, validation, queueing and tick popping.
module tb_ir_cmd_decoder;

  localparam logic [31:0] F_UP    = 32'h20DF6A95;
  localparam logic [31:0] F_DOWN  = 32'h20DFEA15;
  localparam logic [31:0] F_LEFT  = 32'h20DF1AE5;
  localparam logic [31:0] F_RIGHT = 32'h20DF9A65;
  localparam logic [31:0] F_ENTER = 32'h20DF5AA5;
  localparam logic [31:0] F_BADCK = 32'h20DF6A94;
  localparam logic [31:0] F_OTHER = 32'h10EF6A95;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] word;
  logic        game_tick;
  logic [1:0]  dir;
  logic        dir_changed, enter, cmd_err;
  logic [1:0]  fifo_level;

  int n_chk  = 0;
  int n_pass = 0;

  always #10 clk = ~clk;

  ir_cmd_decoder dut (
    .clk         (clk),
    .reset       (reset),
    .word        (word),
    .game_tick   (game_tick),
    .dir         (dir),
    .dir_changed (dir_changed),
    .enter       (enter),
    .cmd_err     (cmd_err),
    .fifo_level  (fifo_level)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Word has just changed (or reset just released): walk to the CHECK edge and look at the pulses.
  task automatic await_check(input string tag, input logic exp_en, input logic exp_err,
                             input logic [1:0] exp_lvl, input logic tick);
    repeat (65) @(posedge clk);
    @(negedge clk);
    chk({tag, "_early"}, {30'd0, enter, cmd_err}, 32'd0);
    game_tick = tick;
    step();
    game_tick = 1'b0;
    chk({tag, "_enter"}, {31'd0, enter}, {31'd0, exp_en});
    chk({tag, "_err"}, {31'd0, cmd_err}, {31'd0, exp_err});
    chk({tag, "_lvl"}, {30'd0, fifo_level}, {30'd0, exp_lvl});
    step();
    chk({tag, "_pulse_end"}, {30'd0, enter, cmd_err}, 32'd0);
  endtask

  task automatic send(input string tag, input logic [31:0] w, input logic exp_en,
                      input logic exp_err, input logic [1:0] exp_lvl, input logic tick);
    word = w;
    await_check(tag, exp_en, exp_err, exp_lvl, tick);
  endtask

  task automatic do_tick(input string tag, input logic [1:0] exp_dir, input logic exp_chg,
                         input logic [1:0] exp_lvl);
    game_tick = 1'b1;
    step();
    game_tick = 1'b0;
    chk({tag, "_dir"}, {30'd0, dir}, {30'd0, exp_dir});
    chk({tag, "_chg"}, {31'd0, dir_changed}, {31'd0, exp_chg});
    chk({tag, "_lvl"}, {30'd0, fifo_level}, {30'd0, exp_lvl});
    step();
    chk({tag, "_chg_end"}, {31'd0, dir_changed}, 32'd0);
  endtask

  task automatic do_reset();
    word  = 32'd0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    game_tick = 1'b0;
    do_reset();
    chk("rst_dir", {30'd0, dir}, 32'd3);
    chk("rst_lvl", {30'd0, fifo_level}, 32'd0);
    chk("rst_pulses", {29'd0, dir_changed, enter, cmd_err}, 32'd0);

    // Basic direction push then pop
    send("up", F_UP, 1'b0, 1'b0, 2'd1, 1'b0);
    do_tick("tick_up", 2'd0, 1'b1, 2'd0);

    send("enter", F_ENTER, 1'b1, 1'b0, 2'd0, 1'b0);
    send("badck", F_BADCK, 1'b0, 1'b1, 2'd0, 1'b0);
    send("addr", F_OTHER, 1'b0, 1'b0, 2'd0, 1'b0);

    // Bouncing word: nothing accepted until it holds still
    for (int i = 0; i < 19; i++) begin
      word = (i % 2 == 0) ? F_RIGHT : F_LEFT;
      repeat (10) step();
      chk("bounce_quiet", {28'd0, fifo_level, enter, cmd_err}, 32'd0);
    end
    send("bounce_final", F_LEFT, 1'b0, 1'b0, 2'd1, 1'b0);
    do_tick("tick_left", 2'd2, 1'b1, 2'd0);

    // Queue fills at two; third is dropped
    do_reset();
    send("q_up", F_UP, 1'b0, 1'b0, 2'd1, 1'b0);
    send("q_left", F_LEFT, 1'b0, 1'b0, 2'd2, 1'b0);
    send("q_down", F_DOWN, 1'b0, 1'b0, 2'd2, 1'b0);
    do_tick("q_t1", 2'd0, 1'b1, 2'd1);
    do_tick("q_t2", 2'd2, 1'b1, 2'd0);
    do_tick("q_empty", 2'd2, 1'b0, 2'd0);

    // Full queue accepts a push when a tick pops in the same cycle
    send("f_up", F_UP, 1'b0, 1'b0, 2'd1, 1'b0);
    send("f_right", F_RIGHT, 1'b0, 1'b0, 2'd2, 1'b0);
    send("f_down_tick", F_DOWN, 1'b0, 1'b0, 2'd2, 1'b1);
    chk("f_pop_dir", {30'd0, dir}, 32'd0);
    do_tick("f_t1", 2'd3, 1'b1, 2'd1);
    do_tick("f_t2", 2'd1, 1'b1, 2'd0);

    // Reset mid-settle with a non-empty queue restarts evaluation from scratch
    send("r_left", F_LEFT, 1'b0, 1'b0, 2'd1, 1'b0);
    word = F_UP;
    repeat (30) step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("r_dir", {30'd0, dir}, 32'd3);
    chk("r_lvl", {30'd0, fifo_level}, 32'd0);
    await_check("r_resettle", 1'b0, 1'b0, 2'd1, 1'b0);

    // Reversal from right to left, pushed with a tick on an empty queue
    do_reset();
`ifdef IR_CMD_REVERSE_BLOCK_EN
    send("rev", F_LEFT, 1'b0, 1'b0, 2'd0, 1'b1);
    chk("rev_dir", {30'd0, dir}, 32'd3);
    do_tick("rev_tick", 2'd3, 1'b0, 2'd0);
`else
    send("rev", F_LEFT, 1'b0, 1'b0, 2'd1, 1'b1);
    chk("rev_dir", {30'd0, dir}, 32'd3);
    do_tick("rev_tick", 2'd2, 1'b1, 2'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
